// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: groups the baud tick, serial line and received-frame
// results between the baud generator / host side and the RX controller.
interface uart_rx_ctrl_if #(
  parameter int DBIT = 8
);
  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            framing_err;
  logic            parity_err;
  logic            busy;

  // Host / stimulus side: supplies tick and line, consumes results.
  modport master (
    output s_tick, rx,
    input  dout, rx_done_tick, framing_err, parity_err, busy
  );

  // Receiver side.
  modport slave (
    input  s_tick, rx,
    output dout, rx_done_tick, framing_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 16x-oversampled UART receive controller.
// Detects the start bit on a synchronized falling edge, samples each data
// bit at mid-bit, checks the stop bit and strobes the received word.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data and stop bits; without it parity_err is tied low.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling DBIT data bits at mid-bit, LSB first
// PARITY | sampling the parity bit (only with UART_RX_PARITY_EN)
// STOP   | waiting SB_TICK ticks, then checking the stop bit
module uart_rx_ctrl #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OS_RATE = 16
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [4:0] MID_CNT  = 5'(OS_RATE / 2 - 1);
  localparam logic [4:0] BIT_CNT  = 5'(OS_RATE - 1);
  localparam logic [4:0] STOP_CNT = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST   = 3'(DBIT - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic            fall;

  state_t          state_q, state_d;
  logic [4:0]      s_cnt_q, s_cnt_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  // Two-flop synchronizer plus previous-value flop; all reset high so
  // leaving reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall = rx_prev_q & ~rx_sync_q;

  // Next-state, counter and output-register logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif

    case (state_q)
      IDLE: begin
        // Ticks are ignored here; only an edge starts a frame.
        if (fall) begin
          state_d = START;
          s_cnt_d = 5'd0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_cnt_q == MID_CNT) begin
            if (!rx_sync_q) begin
              state_d = DATA;
              s_cnt_d = 5'd0;
              n_d     = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_cnt_q == BIT_CNT) begin
            shreg_d = {rx_sync_q, shreg_q[DBIT-1:1]};
            s_cnt_d = 5'd0;
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bus.s_tick) begin
          if (s_cnt_q == BIT_CNT) begin
            par_d   = rx_sync_q;
            s_cnt_d = 5'd0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (bus.s_tick) begin
          if (s_cnt_q == STOP_CNT) begin
            dout_d  = shreg_q;
            ferr_d  = ~rx_sync_q;
            done_d  = 1'b1;
            s_cnt_d = 5'd0;
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            perr_d  = (^shreg_q) ^ par_q;
`endif
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= 5'd0;
      n_q     <= 3'd0;
      shreg_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.framing_err  = ferr_q;
  assign bus.busy         = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_q;
`else
  assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl with a frame scoreboard.
// Honors UART_RX_PARITY_EN to add the parity-bit cases.
module tb_uart_rx_ctrl;

  localparam int TICK_DIV = 20;
  localparam int BIT_CLK  = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_TICKS = 168;
`else
  localparam int EXP_TICKS = 152;
`endif
  localparam int LAT_LO = (EXP_TICKS - 1) * TICK_DIV;
  localparam int LAT_HI = (EXP_TICKS + 1) * TICK_DIV + 3;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    longint     fall_cyc;
  } exp_t;

  logic   clk;
  logic   reset;
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     strobe_cnt = 0;
  int     tdiv = 0;
  exp_t   sb[$];

  uart_rx_ctrl_if #(.DBIT(8)) bus ();

  uart_rx_ctrl #(.DBIT(8), .SB_TICK(16), .OS_RATE(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle count used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Baud tick: one clk high every TICK_DIV clocks.
  initial begin
    bus.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
      bus.s_tick = (tdiv == TICK_DIV - 1);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued frame.
  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      exp_t   e;
      longint lat;
      strobe_cnt++;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_strobe observed=dout %0h expected=no strobe", bus.dout);
      end
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        lat = cyc - e.fall_cyc;
        check("dout", 64'(bus.dout), 64'(e.d));
        check("framing_err", 64'(bus.framing_err), 64'(e.fe));
        check("parity_err", 64'(bus.parity_err), 64'(e.pe));
        total++;
        assert (lat >= LAT_LO && lat <= LAT_HI) else begin
          bad++;
          $error("FAIL latency observed=%0d expected=%0d..%0d clk", lat, LAT_LO, LAT_HI);
        end
      end
    end
  end

  task automatic bit_time();
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Send one frame starting at the current negedge; leaves rx at stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    exp_t e;
    e.d        = d;
    e.fe       = ~stop_b;
`ifdef UART_RX_PARITY_EN
    e.pe       = (^d) ^ par_b;
`else
    e.pe       = 1'b0;
`endif
    e.fall_cyc = cyc;
    sb.push_back(e);
    bus.rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      bit_time();
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = par_b;
    bit_time();
`endif
    bus.rx = stop_b;
    bit_time();
  endtask

  task automatic wait_strobes(input int n);
    int budget = 4000;
    while (strobe_cnt < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (strobe_cnt < n) check("strobe_timeout", 64'(strobe_cnt), 64'(n));
  endtask

  initial begin
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout", 64'(bus.dout), 64'h0);
    check("rst_done", 64'(bus.rx_done_tick), 64'h0);
    check("rst_ferr", 64'(bus.framing_err), 64'h0);
    check("rst_perr", 64'(bus.parity_err), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // Basic frame
    send_frame(8'h55, 1'b1, ^8'h55);
    wait_strobes(1);

    // Back-to-back frames, no idle gap
    send_frame(8'hA3, 1'b1, ^8'hA3);
    send_frame(8'h0F, 1'b1, ^8'h0F);
    wait_strobes(3);
    repeat (100) @(negedge clk);

    // Start glitch: low for 3 ticks only
    bus.rx = 1'b0;
    repeat (3 * TICK_DIV) @(negedge clk);
    check("glitch_busy_hi", 64'(bus.busy), 64'h1);
    bus.rx = 1'b1;
    bit_time();
    check("glitch_busy_lo", 64'(bus.busy), 64'h0);
    check("glitch_dout", 64'(bus.dout), 64'h0F);
    check("glitch_strobes", 64'(strobe_cnt), 64'd3);

    // Stop bit low, then line stuck low
    send_frame(8'hFF, 1'b0, ^8'hFF);
    wait_strobes(4);
    repeat (10 * BIT_CLK) @(negedge clk);
    check("stuck_strobes", 64'(strobe_cnt), 64'd4);
    check("stuck_busy", 64'(bus.busy), 64'h0);
    bus.rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    send_frame(8'h81, 1'b1, ^8'h81);
    wait_strobes(5);
    repeat (100) @(negedge clk);

    // Reset in the middle of DATA, after bit 4 of 0x3C
    bus.rx = 1'b0;
    bit_time();
    for (int i = 0; i < 5; i++) begin
      bus.rx = 1'((8'h3C >> i) & 8'h01);
      bit_time();
    end
    bus.rx = 1'b1;
    repeat (100) @(negedge clk);
    check("mid_busy_pre", 64'(bus.busy), 64'h1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 64'(bus.busy), 64'h0);
    check("mid_rst_dout", 64'(bus.dout), 64'h0);
    check("mid_rst_ferr", 64'(bus.framing_err), 64'h0);
    reset = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("mid_no_strobe", 64'(strobe_cnt), 64'd5);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    wait_strobes(6);

`ifdef UART_RX_PARITY_EN
    // Parity: odd-count data with parity 0 is a mismatch, parity 1 is clean
    repeat (100) @(negedge clk);
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_strobes(8);
`endif

    repeat (50) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
